// File: rtl/onehot_encoder_pipe_pkg.sv
// enc_pkg: shared types and helpers for the one-hot encoder family.
//   enc_status_t  : 2-bit classification of an input vector (OK/NONE/MULTI).
//   ENC_STATUS_W  : width of enc_status_t.
//   enc_width()   : index width for an n-line encoder; never returns 0,
//                   so a degenerate 1-line instance still has a legal port.
package enc_pkg;

  localparam int ENC_STATUS_W = 2;

  typedef enum logic [ENC_STATUS_W-1:0] {
    ENC_OK    = 2'd0,  // exactly one bit set
    ENC_NONE  = 2'd1,  // no bit set
    ENC_MULTI = 2'd2   // more than one bit set, resolved by priority
  } enc_status_t;

  function automatic int enc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_encoder_pipe_prio_enc.sv
// onehot_prio_enc: purely combinational priority encoder with classification.
// Ports:
//   vec   in  N_IN   input lines
//   idx   out OUT_W  index of the winning set bit (0 when vec is zero)
//   zero  out 1      vec has no bit set
//   multi out 1      vec has more than one bit set
// PRIO_MSB selects the winner when several bits are set:
//   0 = lowest set index, 1 = highest set index.
module onehot_prio_enc
  import enc_pkg::*;
#(
  parameter int N_IN     = 10,
  parameter bit PRIO_MSB = 1'b0,
  localparam int OUT_W   = enc_width(N_IN)
) (
  input  logic [N_IN-1:0]  vec,
  output logic [OUT_W-1:0] idx,
  output logic             zero,
  output logic             multi
);

  always_comb begin
    idx = '0;
    // Scan toward the winning end so the last hit is the winner.
    if (PRIO_MSB) begin
      for (int i = 0; i < N_IN; i++) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end
  end

  assign zero  = (vec == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - N_IN'(1)));

endmodule

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: one-hot to binary encoder with a single registered
// output stage behind a valid/ready handshake.
// Optional feature macro: ENC_ERR_CNT_EN (adds err_cnt saturating counter).
// Ports:
//   clk        in   1             rising-edge clock
//   rst_n      in   1             synchronous active-low reset
//   in_valid   in   1             in_vec valid
//   in_ready   out  1             stage can accept this cycle
//   in_vec     in   N_IN          one-hot input (bit k = decimal k)
//   out_valid  out  1             registered result valid
//   out_ready  in   1             downstream accepts result
//   out_idx    out  OUT_W         encoded index
//   out_status out  2             enc_status_t classification
//   err_cnt    out  CNT_W         saturating NONE/MULTI count (macro only)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready = !out_valid || out_ready and does not look at
// in_valid. While out_valid && !out_ready the output is held stable.
// The only state is out_valid itself: EMPTY (0) or FULL (1).
module onehot_encoder_pipe
  import enc_pkg::*;
#(
  parameter int N_IN     = 10,
  parameter bit PRIO_MSB = 1'b0,
  parameter int CNT_W    = 8,
  localparam int OUT_W   = enc_width(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_idx,
  output enc_status_t             out_status
`ifdef ENC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]        err_cnt
`endif
);

  logic [OUT_W-1:0] enc_idx;
  logic             enc_zero;
  logic             enc_multi;
  enc_status_t      enc_status;
  logic             accept;

  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] out_idx_d,   out_idx_q;
  enc_status_t      out_status_d, out_status_q;

  onehot_prio_enc #(
    .N_IN     (N_IN),
    .PRIO_MSB (PRIO_MSB)
  ) u_prio_enc (
    .vec   (in_vec),
    .idx   (enc_idx),
    .zero  (enc_zero),
    .multi (enc_multi)
  );

  always_comb begin
    enc_status = ENC_OK;
    if (enc_zero)       enc_status = ENC_NONE;
    else if (enc_multi) enc_status = ENC_MULTI;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_status_d = out_status_q;
    if (accept) begin
      // Covers both the empty case and the back-to-back replace case.
      out_valid_d  = 1'b1;
      out_idx_d    = enc_idx;
      out_status_d = enc_status;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_status_q <= ENC_OK;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_status_q <= out_status_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_status = out_status_q;

`ifdef ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    // Saturate at all-ones; never wraps.
    if (accept && (enc_status != ENC_OK) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe: directed bench for onehot_encoder_pipe.
// Main instance: N_IN=10, PRIO_MSB=0, CNT_W=2. Side instances cover
// PRIO_MSB=1 and the N_IN=64 / N_IN=2 width extremes; they share the
// handshake inputs with the main instance and have their own in_vec.
module tb_onehot_encoder_pipe;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready;

  logic [9:0]  in_vec;
  logic        in_ready, out_valid;
  logic [3:0]  out_idx;
  enc_status_t out_status;
`ifdef ENC_ERR_CNT_EN
  logic [1:0]  err_cnt;
`endif

  logic [9:0]  m_vec;
  logic        m_in_ready, m_out_valid;
  logic [3:0]  m_idx;
  enc_status_t m_status;

  logic [63:0] w_vec;
  logic        w_in_ready, w_out_valid;
  logic [5:0]  w_idx;
  enc_status_t w_status;

  logic [1:0]  n_vec;
  logic        n_in_ready, n_out_valid;
  logic [0:0]  n_idx;
  enc_status_t n_status;

`ifdef ENC_ERR_CNT_EN
  logic [7:0]  m_cnt, w_cnt, n_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  onehot_encoder_pipe #(.N_IN(10), .PRIO_MSB(1'b0), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_status(out_status)
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  onehot_encoder_pipe #(.N_IN(10), .PRIO_MSB(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_vec(m_vec), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_idx), .out_status(m_status)
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(m_cnt)
`endif
  );

  onehot_encoder_pipe #(.N_IN(64), .PRIO_MSB(1'b0)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_vec(w_vec), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_idx(w_idx), .out_status(w_status)
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(w_cnt)
`endif
  );

  onehot_encoder_pipe #(.N_IN(2), .PRIO_MSB(1'b0)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_vec(n_vec), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_idx(n_idx), .out_status(n_status)
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(n_cnt)
`endif
  );

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge; leave time 1 unit after it for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] vec, input logic rdy);
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [3:0] idx, input enc_status_t st);
    check_val({tag, "_valid"},  64'(out_valid),  64'(v));
    check_val({tag, "_idx"},    64'(out_idx),    64'(idx));
    check_val({tag, "_status"}, 64'(out_status), 64'(st));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] exp_idx;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_vec = '0;
    m_vec = '0; w_vec = '0; n_vec = '0;
    step(); step();
    check_out("reset", 1'b0, 4'd0, ENC_OK);
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // One-hot sweep, back-to-back with out_ready held high.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 10'(1 << k), 1'b1);
      check_val("sweep_in_ready", 64'(in_ready), 64'd1);
      exp_q.push_back(64'(k));
      step();
      exp_idx = exp_q.pop_front();
      check_out("sweep", 1'b1, exp_idx[3:0], ENC_OK);
    end

    // Zero vector.
    drive(1'b1, 10'b0, 1'b1);
    step();
    check_out("zero", 1'b1, 4'd0, ENC_NONE);

    // Multi-hot, both priorities, plus width extremes in the same cycle.
    m_vec = 10'b0000100100;
    w_vec = 64'd1 << 63;
    n_vec = 2'b11;
    drive(1'b1, 10'b0000100100, 1'b1);
    step();
    check_out("multi_lsb", 1'b1, 4'd2, ENC_MULTI);
    check_val("multi_msb_idx",    64'(m_idx),    64'd5);
    check_val("multi_msb_status", 64'(m_status), 64'(ENC_MULTI));
    check_val("w64_idx",          64'(w_idx),    64'd63);
    check_val("w64_status",       64'(w_status), 64'(ENC_OK));
    check_val("w2_idx",           64'(n_idx),    64'd0);
    check_val("w2_status",        64'(n_status), 64'(ENC_MULTI));

    // Opposite ends of the wide/narrow instances.
    m_vec = 10'b1000000001;
    w_vec = (64'd1 << 63) | 64'd1;
    n_vec = 2'b10;
    drive(1'b1, 10'b1000000000, 1'b1);
    step();
    check_out("top_bit", 1'b1, 4'd9, ENC_OK);
    check_val("msb_ends_idx",  64'(m_idx),    64'd9);
    check_val("w64_multi_idx", 64'(w_idx),    64'd0);
    check_val("w64_multi_st",  64'(w_status), 64'(ENC_MULTI));
    check_val("w2_idx1",       64'(n_idx),    64'd1);
    check_val("w2_ok",         64'(n_status), 64'(ENC_OK));

    // Drain: out_ready without a new input clears out_valid.
    drive(1'b0, 10'b0, 1'b1);
    step();
    check_val("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: capture 6, then hold while other vectors are offered.
    drive(1'b1, 10'b0001000000, 1'b0);
    step();
    check_out("bp_load", 1'b1, 4'd6, ENC_OK);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 10'($urandom_range(1, 1023)), 1'b0);
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      check_out("bp_hold", 1'b1, 4'd6, ENC_OK);
    end
    drive(1'b1, 10'b0000001000, 1'b1);
    check_val("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    check_out("bp_release", 1'b1, 4'd3, ENC_OK);

    // Reset beats a simultaneous handshake.
    drive(1'b1, 10'b0010000000, 1'b1);
    step();
    check_out("pre_reset", 1'b1, 4'd7, ENC_OK);
    rst_n = 1'b0;
    drive(1'b1, 10'b0000000100, 1'b1);
    step();
    check_out("mid_reset", 1'b0, 4'd0, ENC_OK);
    rst_n = 1'b1;
    drive(1'b0, 10'b0, 1'b1);
    step();
    check_val("post_reset_valid", 64'(out_valid), 64'd0);

`ifdef ENC_ERR_CNT_EN
    check_val("cnt_reset", 64'(err_cnt), 64'd0);
    for (int z = 0; z < 5; z++) begin
      drive(1'b1, 10'b0, 1'b1);
      step();
      check_val("cnt_sat", 64'(err_cnt), (z < 3) ? 64'(z + 1) : 64'd3);
    end
    drive(1'b1, 10'b0000000010, 1'b1);
    step();
    check_val("cnt_onehot", 64'(err_cnt), 64'd3);
    rst_n = 1'b0;
    drive(1'b0, 10'b0, 1'b1);
    step();
    check_val("cnt_clear", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
- Parametrised, registered successor to the team's 10-line decimal-to-binary encoder.
- Encodes an N-bit one-hot input vector to a binary index over a valid/ready handshake, with one registered output stage.
- Classifies each input as one-hot, zero or multi-hot. Multi-hot inputs are resolved by a configurable priority direction.
- Sits between keypad/decoder front-ends and downstream binary datapaths.

Parameters:
- N_IN, 10, number of input lines; legal range 2..64.
- OUT_W, $clog2(N_IN), width of the binary index; derived, not overridden.
- PRIO_MSB, 0, multi-hot resolution: 0 = lowest set index wins, 1 = highest set index wins.
- CNT_W, 8, width of the error counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input this cycle.
- in_vec  in  N_IN  one-hot input (bit k = decimal k).
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts result.
- out_idx  out  OUT_W  encoded binary index.
- out_status  out  2  enc_status_t: OK=0, NONE=1, MULTI=2.
- err_cnt  out  CNT_W  saturating error count (ENC_ERR_CNT_EN only).

Behaviour:
- Reset (rst_n=0 at a clock edge) forces out_valid=0, out_idx=0, out_status=OK and err_cnt=0.
- Reset has priority over every other event, including a handshake in the same cycle. An in-flight result is discarded.
- in_ready = !out_valid || out_ready. This is combinational; no dependence of in_ready on in_valid.
- Accept occurs when in_valid && in_ready. On the next edge, out_valid=1 and out_idx/out_status are loaded. Latency is 1 cycle.
- Output hold: while out_valid && !out_ready, out_idx and out_status are stable and in_ready=0.
- Back-to-back: if out_valid && out_ready && in_valid, the new result replaces the old one on the same edge. Throughput is 1 per cycle.
- If out_ready && !(in_valid && in_ready), out_valid clears on the next edge.
- Classification, computed combinationally on in_vec and registered on accept:
  - popcount==1: status OK, idx = position of the set bit.
  - in_vec==0: status NONE, idx=0.
  - popcount>1: status MULTI, idx = lowest set index (PRIO_MSB=0) or highest set index (PRIO_MSB=1).
- Bits above N_IN do not exist. out_idx never exceeds N_IN-1.
- in_vec is sampled only on accept. Changes while in_ready=0 are ignored.
- No FSM beyond the out_valid flag: state EMPTY (out_valid=0) or FULL (out_valid=1), with transitions as above.

Optional Feature:
- Macro: ENC_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on each accepted input whose status is NONE or MULTI. It saturates at 2^CNT_W-1 with no wrap and clears only on reset.
- Not defined: the err_cnt port is absent and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Package enc_pkg holds:
  - enc_status_t (2-bit enum OK/NONE/MULTI);
  - function clog2-safe width helper;
  - localparam ENC_STATUS_W=2.
- Sub-module onehot_prio_enc (purely combinational) is parametrised by N_IN and PRIO_MSB.
  - Inputs: vec. Outputs: idx, zero, multi.
  - It is reused by other encoders.
- The top level holds the handshake register and the optional counter.

Test Plan:
- One-hot sweep (N_IN=10, out_ready=1): in_vec=1<<k for k=0..9, one per cycle, back-to-back → out_idx=k one cycle later, status OK, out_valid continuous, in_ready=1 throughout.
- Zero and multi-hot inputs:
  - in_vec=10'b0 → idx=0, status NONE.
  - in_vec=10'b0000100100 with PRIO_MSB=0 → idx=2, MULTI.
  - Same vector with PRIO_MSB=1 → idx=5, MULTI.
- Backpressure: accept 10'b0001000000, hold out_ready=0 for 4 cycles while driving other in_vec values → out_idx=6 stable, in_ready=0, no further accept. Raise out_ready → next input accepted that edge.
- Reset mid-operation: out_valid=1, out_idx=7; assert rst_n=0 for one edge with in_valid=1 → out_valid=0, idx=0, status OK; no capture of that input.
- ENC_ERR_CNT_EN with CNT_W=2: feed 5 zero vectors → err_cnt sequence 1,2,3,3,3. A one-hot input leaves it at 3. Reset → 0.
- Width scaling: N_IN=64 (OUT_W=6), in_vec=1<<63 → idx=63. N_IN=2, in_vec=2'b11, PRIO_MSB=0 → idx=0, MULTI.
